// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the K=3 hard-decision Viterbi decoder: gathers one frame of
// symbols, picks the best end state, runs traceback and hands the byte to the sink.
module viterbi_frame_ctrl #(
   parameter int FRAME_LEN  = 8,
   parameter int PM_W       = 8,
   parameter int TB_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_sym_valid,
   output logic            o_sym_ready,
   output logic            o_en_acs,
   output logic [2:0]      o_wr_addr,
   output logic [2:0]      o_rd_addr,
   input  logic [PM_W-1:0] i_pm_00,
   input  logic [PM_W-1:0] i_pm_01,
   input  logic [PM_W-1:0] i_pm_10,
   input  logic [PM_W-1:0] i_pm_11,
   output logic [1:0]      o_select_node,
   output logic            o_en_traceback,
   input  logic            i_tb_done,
   input  logic [7:0]      i_tb_data,
   output logic [7:0]      o_data,
   output logic            o_data_valid,
   input  logic            i_data_ready,
   output logic            o_err
);

   localparam int TW = $clog2(TB_TIMEOUT + 1);
   localparam logic [2:0]    LAST_ADDR = 3'(FRAME_LEN - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TB_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ACCEPT = 3'd1,
      SELECT = 3'd2,
      TRACE  = 3'd3,
      OUTPUT = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      wr_addr_q, wr_addr_d;
   logic [2:0]      rd_addr_q, rd_addr_d;
   logic [1:0]      sel_q, sel_d;
   logic [7:0]      data_q, data_d;
   logic            err_q, err_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            hs;
   logic            frame_full;
   logic            tmo_hit;

   // Strict less-than scan in index order keeps ties on the lowest state.
   function automatic logic [1:0] argmin4(input logic [PM_W-1:0] p0, input logic [PM_W-1:0] p1,
                                          input logic [PM_W-1:0] p2, input logic [PM_W-1:0] p3);
      logic [1:0]      idx;
      logic [PM_W-1:0] best;
      idx  = 2'd0;
      best = p0;
      if (p1 < best) begin idx = 2'd1; best = p1; end
      if (p2 < best) begin idx = 2'd2; best = p2; end
      if (p3 < best) begin idx = 2'd3; best = p3; end
      return idx;
   endfunction

   assign hs         = i_sym_valid && (state_q == ACCEPT);
   assign frame_full = hs && (wr_addr_q == LAST_ADDR);
   assign tmo_hit    = (tmo_q == TMO_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = ACCEPT;
         ACCEPT:  if (frame_full) state_d = SELECT;
         SELECT:  state_d = TRACE;
         TRACE:   if (i_tb_done || tmo_hit) state_d = i_tb_done ? OUTPUT : ACCEPT;
         OUTPUT:  if (i_data_ready) state_d = ACCEPT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_sym_ready    = (state_q == ACCEPT);
      o_en_acs       = hs;
      o_en_traceback = (state_q == TRACE);
      o_data_valid   = (state_q == OUTPUT);
      o_wr_addr      = wr_addr_q;
      o_rd_addr      = rd_addr_q;
      o_select_node  = sel_q;
      o_data         = data_q;
      o_err          = err_q;
   end

   // Datapath next values; the write address only clears when a frame is finished
   // or dropped, so it never wraps past the last symbol index.
   always_comb begin
      wr_addr_d = wr_addr_q;
      rd_addr_d = rd_addr_q;
      sel_d     = sel_q;
      data_d    = data_q;
      tmo_d     = tmo_q;
      err_d     = 1'b0;
      case (state_q)
         ACCEPT: begin
            if (hs && !frame_full) wr_addr_d = wr_addr_q + 3'd1;
         end
         SELECT: begin
            sel_d     = argmin4(i_pm_00, i_pm_01, i_pm_10, i_pm_11);
            rd_addr_d = LAST_ADDR;
            tmo_d     = '0;
         end
         TRACE: begin
            if (rd_addr_q != 3'd0) rd_addr_d = rd_addr_q - 3'd1;
            if (!tmo_hit) tmo_d = tmo_q + TW'(1);
            if (i_tb_done) begin
               data_d = i_tb_data;
            end else if (tmo_hit) begin
               err_d     = 1'b1;
               wr_addr_d = 3'd0;
            end
         end
         OUTPUT: begin
            if (i_data_ready) wr_addr_d = 3'd0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_addr_q <= 3'd0;
         rd_addr_q <= 3'd0;
         sel_q     <= 2'd0;
         data_q    <= 8'd0;
         tmo_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
         sel_q     <= sel_d;
         data_q    <= data_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
      end
   end

endmodule
